// File: rtl/mod114689_pkg.sv
// Shared constants and types for the signed mod-114689 arithmetic blocks.
package mod114689_pkg;

   localparam int Q     = 114689;
   localparam int QH    = 57344;
   localparam int EXP_W = 17;
   localparam logic [EXP_W-1:0] EXP = 17'd114687;

   typedef logic signed [16:0] residue_t;

   typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

endpackage

// File: rtl/modmulred114689s.sv
// Fixed-latency signed 17x17 multiply with reduction into [-QH, QH].
module modmulred114689s
   import mod114689_pkg::*;
#(
   parameter int LAT = 4
)
(
   input  logic     clk,
   input  logic     rst,
   input  residue_t a,
   input  residue_t b,
   output residue_t p
);

   localparam logic signed [32:0] Q33  = 33'sd114689;
   localparam logic signed [32:0] QH33 = 33'sd57344;

   logic signed [32:0] prod;
   logic signed [32:0] rem;
   logic signed [32:0] remPos;
   logic signed [32:0] remCtr;
   residue_t stage [LAT-1];

   // Remainder takes the dividend's sign; fold to [0,Q) then centre on zero.
   always_comb begin
      rem    = prod % Q33;
      remPos = (rem < 0) ? rem + Q33 : rem;
      remCtr = (remPos > QH33) ? remPos - Q33 : remPos;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod <= '0;
         for (int k = 0; k < LAT-1; k++) stage[k] <= '0;
      end else begin
         prod     <= 33'(a) * 33'(b);
         stage[0] <= 17'(remCtr);
         for (int k = 1; k < LAT-1; k++) stage[k] <= stage[k-1];
      end
   end

   assign p = stage[LAT-2];

endmodule

// File: rtl/modinv114689s.sv
// Signed modular inverter mod 114689 via left-to-right Fermat exponentiation.
module modinv114689s
   import mod114689_pkg::*;
#(
   parameter int LAT = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic signed [16:0] inA,
   input  logic               in_valid,
   output logic               in_ready,
   output logic signed [16:0] outZ,
   output logic               out_zero,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam logic [3:0] CNT_LOAD = 4'(LAT-1);

   state_t   state, stateNext;
   residue_t r, rNext;
   residue_t base, baseNext;
   residue_t opA, opB, prodR;
   logic [3:0] idx, idxNext;
   logic [3:0] cnt, cntNext;
   logic       first, firstNext;

   modmulred114689s #(.LAT(LAT)) uMulRed (
      .clk (clk),
      .rst (rst),
      .a   (opA),
      .b   (opB),
      .p   (prodR)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         r     <= '0;
         base  <= '0;
         idx   <= '0;
         cnt   <= '0;
         first <= 1'b0;
      end else begin
         state <= stateNext;
         r     <= rNext;
         base  <= baseNext;
         idx   <= idxNext;
         cnt   <= cntNext;
         first <= firstNext;
      end
   end

   // The result cycle also issues the next step, forwarding the product directly.
   always_comb begin
      stateNext = state;
      rNext     = r;
      baseNext  = base;
      idxNext   = idx;
      cntNext   = cnt;
      firstNext = first;
      opA       = r;
      opB       = r;
      case (state)
         IDLE: begin
            if (in_valid) begin
               stateNext = SQR;
               rNext     = inA;
               baseNext  = inA;
               idxNext   = 4'd15;
               cntNext   = '0;
               firstNext = 1'b1;
            end
         end
         SQR, MUL: begin
            if (first) begin
               firstNext = 1'b0;
               cntNext   = CNT_LOAD;
            end else if (cnt != 4'd0) begin
               cntNext = cnt - 4'd1;
            end else begin
               rNext   = prodR;
               opA     = prodR;
               opB     = prodR;
               cntNext = CNT_LOAD;
               if (state == SQR && EXP[idx]) begin
                  stateNext = MUL;
                  opB       = base;
               end else if (idx == 4'd0) begin
                  stateNext = DONE;
               end else begin
                  idxNext   = idx - 4'd1;
                  stateNext = SQR;
               end
            end
         end
         DONE: begin
            if (out_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign outZ      = out_valid ? r : '0;
   assign out_zero  = out_valid && (r == '0);

endmodule

// File: tb/tb_modinv114689s.sv
// Self-checking bench for modinv114689s against an extended-Euclid inverse model.
module tb_modinv114689s;

   localparam int     LAT = 4;
   localparam longint Q   = 114689;
   localparam longint QH  = 57344;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [16:0] inA;
   logic               in_valid;
   logic               in_ready;
   logic signed [16:0] outZ;
   logic               out_zero;
   logic               out_valid;
   logic               out_ready;

   int checks = 0;
   int errors = 0;

   modinv114689s #(.LAT(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .inA       (inA),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .outZ      (outZ),
      .out_zero  (out_zero),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Inverse by extended Euclid, mapped into the centred range [-QH, QH].
   function automatic longint refInv(input longint a);
      longint t = 0, newT = 1, rr = Q, newR, q, tmp;
      newR = ((a % Q) + Q) % Q;
      if (newR == 0) return 0;
      while (newR != 0) begin
         q    = rr / newR;
         tmp  = t - q * newT;
         t    = newT;
         newT = tmp;
         tmp  = rr - q * newR;
         rr   = newR;
         newR = tmp;
      end
      if (t < 0) t += Q;
      if (t > QH) t -= Q;
      return t;
   endfunction

   task automatic applyStimulus(input longint a, output int edges);
      int w = 0;
      while (!in_ready && w < 1000) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) checkOutput("in_ready_wait", 0, 1);
      inA      = 17'(a);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      edges = 0;
      while (!out_valid && edges < 2000) begin
         @(posedge clk);
         edges++;
         #1;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic verifyOp(input string tag, input longint expZ, input int edges);
      checkOutput({tag, "_lat"}, edges, 31*LAT + 1);
      checkOutput({tag, "_z"}, outZ, expZ);
      checkOutput({tag, "_zero"}, out_zero, (expZ == 0) ? 1 : 0);
   endtask

   initial begin
      longint dirIn  [6] = '{1, -1, 2, 7, -16384, 0};
      longint dirOut [6] = '{1, -1, -57344, -16384, 7, 0};
      longint a, z, expZ;
      int edges, bad;

      rst = 1'b1; inA = '0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_outZ", outZ, 0);
      checkOutput("rst_out_zero", out_zero, 0);
      #20 rst = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 6; k++) begin
         applyStimulus(dirIn[k], edges);
         verifyOp($sformatf("dir%0d", dirIn[k]), dirOut[k], edges);
         handshake();
      end

      // Back-pressure with a second operand offered throughout.
      applyStimulus(5, edges);
      expZ = refInv(5);
      verifyOp("bp_first", expZ, edges);
      inA = 17'sd9; in_valid = 1'b1;
      bad = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk); #1;
         if (!out_valid || outZ != 17'(expZ) || in_ready) bad++;
      end
      checkOutput("bp_stable", bad, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("bp_ready_after_hs", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("bp_second_taken", in_ready, 0);
      edges = 0;
      while (!out_valid && edges < 2000) begin
         @(posedge clk);
         edges++;
         #1;
      end
      verifyOp("bp_second", refInv(9), edges);
      handshake();

      // Asynchronous reset in the middle of an inversion.
      inA = 17'sd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (60) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("arst_out_valid", out_valid, 0);
      checkOutput("arst_in_ready", in_ready, 1);
      checkOutput("arst_outZ", outZ, 0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus(11, edges);
      verifyOp("post_rst", refInv(11), edges);
      handshake();

      // Random sweep over the non-zero operand range.
      for (int k = 0; k < 150; k++) begin
         do a = longint'($urandom_range(0, 114688)) - QH; while (a == 0);
         applyStimulus(a, edges);
         z = outZ;
         checkOutput($sformatf("rnd%0d_z", a), z, refInv(a));
         checkOutput($sformatf("rnd%0d_prod", a), (((a * z) % Q) + Q) % Q, 1);
         checkOutput($sformatf("rnd%0d_lat", a), edges, 31*LAT + 1);
         handshake();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
